// File: rtl/sha3_msg_packer.sv
// sha3_msg_packer: packs W-bit message words MSB-first into one N-bit block for the sha3 core.
// Optional SHA3_PACK_PREFILL_EN adds a shadow buffer that collects the next block during REQ/HOLD.
module sha3_msg_packer #(
    parameter int N = 128,
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [W-1:0] s_data,
    input  logic         s_valid,
    input  logic         s_last,
    output logic         s_ready,
    output logic [N-1:0] md_in,
    output logic         req_valid,
    input  logic         req_ready,
    input  logic         res_valid,
    input  logic         res_ready,
    output logic         len_err,
    output logic [15:0]  blk_cnt
);
    localparam int K  = N / W;
    localparam int IW = (K > 1) ? $clog2(K) : 1;
    localparam logic [IW-1:0] LAST_IDX = IW'(K - 1);

    typedef enum logic [1:0] {FILL, REQ, HOLD} state_t;

    state_t        state, state_n;
    logic [IW-1:0] idx, idx_n, widx;
    logic [N-1:0]  md_n;
    logic          s_ready_n, req_valid_n, len_err_n;
    logic [15:0]   blk_cnt_n;
    logic          take, close, err, done;

`ifdef SHA3_PACK_PREFILL_EN
    logic [N-1:0]  sh, sh_n;
    logic [IW-1:0] sh_idx, sh_idx_n;
    logic          sh_closed, sh_closed_n, sh_err, sh_err_n;
    assign widx = (state == FILL) ? idx : sh_idx;
`else
    assign widx = idx;
`endif

    assign take  = s_valid && s_ready;
    assign close = take && (s_last || widx == LAST_IDX);
    // Only an s_last landing exactly on the final slot forms a well-sized block.
    assign err   = close && !(s_last && widx == LAST_IDX);
    assign done  = res_valid && res_ready;

    always_comb begin
        state_n     = state;
        idx_n       = idx;
        md_n        = md_in;
        s_ready_n   = s_ready;
        req_valid_n = req_valid;
        len_err_n   = 1'b0;
        blk_cnt_n   = blk_cnt;
`ifdef SHA3_PACK_PREFILL_EN
        sh_n        = sh;
        sh_idx_n    = sh_idx;
        sh_closed_n = sh_closed;
        sh_err_n    = sh_err;
        if (take && state != FILL) begin
            sh_n[N-1-int'(sh_idx)*W -: W] = s_data;
            sh_idx_n    = close ? '0 : sh_idx + IW'(1);
            sh_closed_n = close;
            sh_err_n    = err;
        end
`endif
        unique case (state)
            FILL: begin
                s_ready_n = 1'b1;
                if (take) begin
                    md_n[N-1-int'(idx)*W -: W] = s_data;
                    idx_n = idx + IW'(1);
                end
                if (close) begin
                    idx_n       = '0;
                    state_n     = REQ;
                    req_valid_n = 1'b1;
                    len_err_n   = err;
`ifdef SHA3_PACK_PREFILL_EN
                    s_ready_n   = 1'b1;
`else
                    s_ready_n   = 1'b0;
`endif
                end
            end
            REQ: begin
                if (req_ready) begin
                    req_valid_n = 1'b0;
                    state_n     = HOLD;
                end
            end
            HOLD: begin
                if (done) begin
                    blk_cnt_n = blk_cnt + 16'd1;
                    s_ready_n = 1'b1;
`ifdef SHA3_PACK_PREFILL_EN
                    // The shadow image includes any word accepted on this same edge.
                    md_n = sh_n;
                    if (sh_closed_n) begin
                        state_n     = REQ;
                        req_valid_n = 1'b1;
                        len_err_n   = sh_err_n;
                        idx_n       = '0;
                    end else begin
                        state_n = FILL;
                        idx_n   = sh_idx_n;
                    end
                    sh_n        = '0;
                    sh_idx_n    = '0;
                    sh_closed_n = 1'b0;
                    sh_err_n    = 1'b0;
`else
                    md_n    = '0;
                    idx_n   = '0;
                    state_n = FILL;
`endif
                end
            end
            default: state_n = FILL;
        endcase
`ifdef SHA3_PACK_PREFILL_EN
        if (state != FILL && !(state == HOLD && done))
            s_ready_n = !sh_closed_n;
`endif
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= FILL;
            idx       <= '0;
            md_in     <= '0;
            s_ready   <= 1'b0;
            req_valid <= 1'b0;
            len_err   <= 1'b0;
            blk_cnt   <= '0;
`ifdef SHA3_PACK_PREFILL_EN
            sh        <= '0;
            sh_idx    <= '0;
            sh_closed <= 1'b0;
            sh_err    <= 1'b0;
`endif
        end else begin
            state     <= state_n;
            idx       <= idx_n;
            md_in     <= md_n;
            s_ready   <= s_ready_n;
            req_valid <= req_valid_n;
            len_err   <= len_err_n;
            blk_cnt   <= blk_cnt_n;
`ifdef SHA3_PACK_PREFILL_EN
            sh        <= sh_n;
            sh_idx    <= sh_idx_n;
            sh_closed <= sh_closed_n;
            sh_err    <= sh_err_n;
`endif
        end
    end
endmodule

// File: tb/tb_sha3_msg_packer.sv
// tb_sha3_msg_packer: scoreboard bench for sha3_msg_packer (N=128, W=32) with a simple core model.
`timescale 1ns/1ps
module tb_sha3_msg_packer;
    localparam int N = 128;
    localparam int W = 32;
    localparam int K = N / W;
`ifdef SHA3_PACK_PREFILL_EN
    localparam logic PREFILL = 1'b1;
`else
    localparam logic PREFILL = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic [W-1:0] s_data = '0;
    logic         s_valid = 1'b0;
    logic         s_last = 1'b0;
    logic         s_ready;
    logic [N-1:0] md_in;
    logic         req_valid;
    logic         req_ready = 1'b0;
    logic         res_valid = 1'b0;
    logic         res_ready = 1'b0;
    logic         len_err;
    logic [15:0]  blk_cnt;

    typedef struct {
        logic [N-1:0] md;
        logic         err;
    } blk_t;

    blk_t         q[$];
    logic [N-1:0] m_md = '0;
    int           m_idx = 0;
    logic [15:0]  exp_blk = '0;
    int           vectors = 0;
    int           miscompares = 0;

    always #5 clk = ~clk;

    sha3_msg_packer #(.N(N), .W(W)) dut (
        .clk(clk), .rst_n(rst_n), .s_data(s_data), .s_valid(s_valid), .s_last(s_last),
        .s_ready(s_ready), .md_in(md_in), .req_valid(req_valid), .req_ready(req_ready),
        .res_valid(res_valid), .res_ready(res_ready), .len_err(len_err), .blk_cnt(blk_cnt)
    );

    initial begin
        #500us;
        $display("FAIL watchdog: simulation time limit reached, want completion");
        $fatal(1);
    end

    task automatic model_word(input logic [W-1:0] d, input logic l);
        m_md[N-1-m_idx*W -: W] = d;
        if (l || m_idx == K - 1) begin
            q.push_back('{md: m_md, err: !(l && m_idx == K - 1)});
            m_md  = '0;
            m_idx = 0;
        end else begin
            m_idx++;
        end
    endtask

    // Called at a falling edge; returns at the falling edge after acceptance.
    task automatic send_word(input logic [W-1:0] d, input logic l);
        int n = 0;
        s_data  = d;
        s_last  = l;
        s_valid = 1'b1;
        while (s_ready !== 1'b1 && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (s_ready !== 1'b1) begin
            vectors++;
            miscompares++;
            $display("FAIL send_timeout: s_ready=%b after %0d cycles, want 1", s_ready, n);
        end else begin
            @(negedge clk);
            model_word(d, l);
        end
        s_valid = 1'b0;
        s_last  = 1'b0;
    endtask

    task automatic serve_req();
        int   n = 0;
        blk_t e;
        while (req_valid !== 1'b1 && n < 200) begin
            @(negedge clk);
            n++;
        end
        vectors++;
        if (req_valid !== 1'b1) begin
            miscompares++;
            $display("FAIL req_timeout: req_valid=%b after %0d cycles, want 1", req_valid, n);
            return;
        end
        vectors++;
        if (q.size() == 0) begin
            miscompares++;
            $display("FAIL sb_empty: got unexpected block %h, want none", md_in);
            return;
        end
        e = q.pop_front();
        vectors++;
        if (md_in !== e.md) begin
            miscompares++;
            $display("FAIL req_md: got %h want %h", md_in, e.md);
        end
        vectors++;
        if (len_err !== e.err) begin
            miscompares++;
            $display("FAIL len_err_rise: got %b want %b", len_err, e.err);
        end
        vectors++;
        if (s_ready !== PREFILL) begin
            miscompares++;
            $display("FAIL req_s_ready: got %b want %b", s_ready, PREFILL);
        end
        @(negedge clk);
        vectors++;
        if (len_err !== 1'b0) begin
            miscompares++;
            $display("FAIL len_err_pulse: got %b want 0", len_err);
        end
        req_ready = 1'b1;
        @(negedge clk);
        req_ready = 1'b0;
        vectors++;
        if (req_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL req_drop: got %b want 0", req_valid);
        end
    endtask

    task automatic serve_res(input int hold, input logic chained);
        logic [N-1:0] cap;
        cap       = md_in;
        res_valid = 1'b1;
        res_ready = 1'b0;
        req_ready = (hold > 0);
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            req_ready = 1'b0;
            vectors++;
            if (md_in !== cap || req_valid !== 1'b0) begin
                miscompares++;
                $display("FAIL hold_frozen: got md=%h req_valid=%b want md=%h req_valid=0",
                         md_in, req_valid, cap);
            end
        end
        res_ready = 1'b1;
        @(negedge clk);
        res_valid = 1'b0;
        res_ready = 1'b0;
        exp_blk++;
        vectors++;
        if (blk_cnt !== exp_blk) begin
            miscompares++;
            $display("FAIL blk_cnt: got %0d want %0d", blk_cnt, exp_blk);
        end
        if (chained) begin
            vectors++;
            if (req_valid !== 1'b1) begin
                miscompares++;
                $display("FAIL chain_req: got req_valid=%b want 1", req_valid);
            end
        end else begin
            vectors++;
            if (s_ready !== 1'b1 || req_valid !== 1'b0) begin
                miscompares++;
                $display("FAIL hold_exit: got s_ready=%b req_valid=%b want 1/0", s_ready, req_valid);
            end
            vectors++;
            if (md_in !== '0) begin
                miscompares++;
                $display("FAIL buf_clear: got %h want 0", md_in);
            end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        vectors++;
        if ({s_ready, req_valid, len_err} !== 3'b000 || blk_cnt !== 16'h0) begin
            miscompares++;
            $display("FAIL reset_ctl: got s_ready/req_valid/len_err=%b%b%b blk_cnt=%0d want 000/0",
                     s_ready, req_valid, len_err, blk_cnt);
        end
        vectors++;
        if (md_in !== '0) begin
            miscompares++;
            $display("FAIL reset_md: got %h want 0", md_in);
        end
        rst_n = 1'b1;
        @(negedge clk);
        vectors++;
        if (s_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL reset_release: got s_ready=%b want 1", s_ready);
        end
    endtask

    task automatic test_full();
        send_word(32'h00112233, 1'b0);
        send_word(32'h44556677, 1'b0);
        send_word(32'h8899AABB, 1'b0);
        send_word(32'hCCDDEEFF, 1'b1);
        vectors++;
        if (req_valid !== 1'b1 || s_ready !== PREFILL) begin
            miscompares++;
            $display("FAIL close_latency: got req_valid=%b s_ready=%b want 1/%b",
                     req_valid, s_ready, PREFILL);
        end
        serve_req();
        serve_res(3, 1'b0);
    endtask

    task automatic test_short();
        send_word(32'hDEADBEEF, 1'b0);
        send_word(32'h01020304, 1'b1);
        serve_req();
        serve_res(2, 1'b0);
    endtask

    task automatic test_no_last();
        for (int i = 0; i < K; i++) send_word(32'h10000000 * (i + 1) + 32'h0000ABCD, 1'b0);
        serve_req();
        serve_res(1, 1'b0);
        send_word(32'h55AA55AA, 1'b1);
        serve_req();
        serve_res(1, 1'b0);
    endtask

`ifndef SHA3_PACK_PREFILL_EN
    task automatic test_hold_stall();
        send_word(32'hCAFEF00D, 1'b0);
        send_word(32'h0BADC0DE, 1'b0);
        send_word(32'h12345678, 1'b0);
        send_word(32'h9ABCDEF0, 1'b1);
        s_data  = 32'hA5A5A5A5;
        s_last  = 1'b1;
        s_valid = 1'b1;
        serve_req();
        serve_res(20, 1'b0);
        model_word(32'hA5A5A5A5, 1'b1);
        @(negedge clk);
        s_valid = 1'b0;
        s_last  = 1'b0;
        vectors++;
        if (req_valid !== 1'b1) begin
            miscompares++;
            $display("FAIL resume_accept: got req_valid=%b want 1", req_valid);
        end
        serve_req();
        serve_res(2, 1'b0);
    endtask
`else
    task automatic test_prefill();
        send_word(32'h11111111, 1'b0);
        send_word(32'h22222222, 1'b0);
        send_word(32'h33333333, 1'b0);
        send_word(32'h44444444, 1'b1);
        serve_req();
        send_word(32'hAAAA0001, 1'b0);
        send_word(32'hBBBB0002, 1'b0);
        send_word(32'hCCCC0003, 1'b0);
        send_word(32'hDDDD0004, 1'b1);
        vectors++;
        if (s_ready !== 1'b0) begin
            miscompares++;
            $display("FAIL shadow_full: got s_ready=%b want 0", s_ready);
        end
        serve_res(2, 1'b1);
        serve_req();
        serve_res(1, 1'b0);
    endtask
`endif

    task automatic test_reset_mid();
        for (int i = 0; i < K; i++) send_word(32'hF0F0F0F0 ^ i, i == K - 1);
        rst_n = 1'b0;
        @(negedge clk);
        vectors++;
        if ({s_ready, req_valid, len_err} !== 3'b000 || blk_cnt !== 16'h0 || md_in !== '0) begin
            miscompares++;
            $display("FAIL mid_reset: got s_ready/req_valid/len_err=%b%b%b blk_cnt=%0d md=%h want zeros",
                     s_ready, req_valid, len_err, blk_cnt, md_in);
        end
        q.delete();
        m_md    = '0;
        m_idx   = 0;
        exp_blk = '0;
        rst_n   = 1'b1;
        @(negedge clk);
        send_word(32'h0A0B0C0D, 1'b0);
        send_word(32'h1A1B1C1D, 1'b0);
        send_word(32'h2A2B2C2D, 1'b0);
        send_word(32'h3A3B3C3D, 1'b1);
        serve_req();
        serve_res(1, 1'b0);
    endtask

    initial begin
        test_reset();
        test_full();
        test_short();
        test_no_last();
`ifndef SHA3_PACK_PREFILL_EN
        test_hold_stall();
`else
        test_prefill();
`endif
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/sha3_msg_packer.md
# sha3_msg_packer

Upstream feeder for the `sha3` digest core. Accepts a message as a stream of W-bit words and packs them MSB-first into one N-bit block. Presents the block on `md_in` with the core's `req_valid`/`req_ready` handshake. Holds `md_in` stable until the core's result handshake completes, because the core samples `md_in` combinationally during the whole permutation.

## Interface
- `N`, 128: block width in bits; must equal the core's `N`, be a multiple of `W`, and satisfy N ≤ 568.
- `W`, 32: input word width in bits; must be a multiple of 8.
- `clk`  in  1: sole clock; all logic on its rising edge.
- `rst_n`  in  1: reset, synchronous and active-low.
- `s_data`  in  W: message word; the first word of a message lands in `md_in[N-1:N-W]`.
- `s_valid`  in  1: `s_data`/`s_last` valid.
- `s_last`  in  1: marks the final word of a message.
- `s_ready`  out  1: packer accepts a word this cycle.
- `md_in`  out  N: packed block to the core.
- `req_valid`  out  1: block request to the core.
- `req_ready`  in  1: core acknowledge (one-cycle pulse).
- `res_valid`  in  1: snooped core result valid.
- `res_ready`  in  1: snooped consumer result ready.
- `len_err`  out  1: one-cycle pulse on a length violation.
- `blk_cnt`  out  16: blocks completed; wraps from 0xFFFF to 0.

## Operation
- K = N/W words per block. The word index counts 0..K-1, with width clog2(K) and a minimum of 1.
- A word is accepted when `s_valid && s_ready`. Word i is written to `md_in[N-1-i*W -: W]`.
- The block closes on the K-th accepted word or on an accepted `s_last`, whichever comes first.
- Short close (`s_last` at index k < K-1):
  - words k+1..K-1 are zero;
  - `len_err` pulses.
- Full close without `s_last` on word K-1:
  - `len_err` pulses;
  - the next accepted word starts a new block.
- States:
  - FILL: `s_ready`=1. Go to REQ on block close.
  - REQ: `s_ready`=0, `req_valid`=1. On `req_ready`=1, drop `req_valid` and go to HOLD.
  - HOLD: `s_ready`=0, `md_in` frozen. On `res_valid && res_ready`, increment `blk_cnt`, clear the buffer, and go to FILL.
- `req_ready` seen in FILL or HOLD is ignored.
- `res_valid && res_ready` seen outside HOLD is ignored.
- `s_valid` is ignored while `s_ready`=0. The upstream must hold its word.

## Timing
- All outputs are registered.
- Values while `rst_n`=0: `s_ready`=0, `md_in`=0, `req_valid`=0, `len_err`=0, `blk_cnt`=0, state FILL, index 0.
- `s_ready` rises on the first cycle after `rst_n` goes high.
- Closing word accepted at edge t: `req_valid`=1 and `s_ready`=0 from t+1.
- `len_err` asserts in the same cycle as the `req_valid` rise.
- The core answers `req_ready` at t+2. `req_valid` falls at t+3.
- HOLD exit at edge h: `s_ready`=1 from h+1.
- Best-case input throughput is one word per cycle within a block.
- Reset mid-operation returns to FILL with cleared buffers. The core must be reset in the same cycle.

## Configuration
- `SHA3_PACK_PREFILL_EN` defined:
  - adds an N-bit shadow buffer and index;
  - `s_ready`=1 during REQ/HOLD until the shadow closes.
  - On HOLD exit, the shadow copies into `md_in`:
    - if the shadow is closed, go directly to REQ with `req_valid`=1 at h+1, and a pending `len_err` pulses then;
    - if the shadow is partial, resume FILL at the shadow index.
  - Shadow closing rules match FILL.
- Undefined: single buffer; `s_ready`=0 throughout REQ and HOLD.

## Test plan
- N=128, W=32: words 0x00112233, 0x44556677, 0x8899AABB, 0xCCDDEEFF with last on word 3 -> `md_in`=0x00112233_44556677_8899AABB_CCDDEEFF; `req_valid` 1 cycle after word 3; `len_err`=0; `blk_cnt`=1 after the result handshake.
- Two words 0xDEADBEEF, 0x01020304 with last on word 1 -> `md_in`=0xDEADBEEF_01020304_00000000_00000000; `len_err` pulses once, aligned with the `req_valid` rise.
- Four words with no `s_last` -> block closes; `len_err` pulses; the fifth word lands in the next block at index 0.
- `s_valid` held during HOLD with `res_ready`=0 for 20 cycles -> `md_in` unchanged; no word accepted (macro off); accept resumes the cycle after the handshake.
- `rst_n` pulled low during REQ -> all outputs at reset values next cycle; a fresh 4-word message then completes normally.
- With `SHA3_PACK_PREFILL_EN`: a second 4-word message streamed during HOLD -> all 4 words accepted; `req_valid` rises 1 cycle after the first result handshake with the second block on `md_in`.
